ifu_fetch: RTL and testbench

Instruction fetch unit sitting directly upstream of the IF/ID pipeline register. It owns the program counter and issues in-order word fetches to instruction memory over a request/grant/rvalid handshake. Returned words and their addresses are buffered in a small prefetch FIFO. The FIFO head drives the IF/ID register's instruction and address inputs. Jumps redirect the PC, flush the FIFO and discard responses still in flight.

---
 rtl/ifu_fetch.sv | 131 +++++++++++++
 tb/tb_ifu_fetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues in-order word fetches, buffers {addr, inst} in a prefetch FIFO.
// Head is valid two cycles after grant (one with IFU_BYPASS_EN); hold_flag_i stalls consumption only.
module ifu_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        fetch_stall_o
);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fa_q [DEPTH];
    logic [31:0]   fi_q [DEPTH];
    logic [31:0]   oa_q [DEPTH];
    logic [PW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d, o_rd_q, o_rd_d, o_wr_q, o_wr_d;
    logic [CW-1:0] f_cnt_q, f_cnt_d, o_cnt_q, o_cnt_d, d_cnt_q, d_cnt_d;

    logic [CW:0]   occ;
    logic          grant, rsp_vld, rsp_keep, fifo_vld, byp, f_push, f_pop;
    logic [31:0]   rsp_addr;

    // Outstanding requests count against capacity, so a response always finds a free FIFO slot.
    assign occ         = {1'b0, o_cnt_q} + {1'b0, f_cnt_q};
    assign imem_req_o  = !rst && !jump_flag_i && (occ < DEPTH_W);
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    assign rsp_vld  = !rst && imem_rvalid_i && (o_cnt_q != '0);
    assign rsp_addr = oa_q[o_rd_q];
    assign rsp_keep = rsp_vld && !jump_flag_i && (d_cnt_q == '0);
    assign fifo_vld = !rst && !jump_flag_i && (f_cnt_q != '0);

`ifdef IFU_BYPASS_EN
    assign byp = rsp_keep && (f_cnt_q == '0);
`else
    assign byp = 1'b0;
`endif

    assign inst_valid_o  = fifo_vld || byp;
    assign fetch_stall_o = !inst_valid_o;
    assign f_pop         = fifo_vld && !hold_flag_i;
    assign f_push        = rsp_keep && !(byp && !hold_flag_i);

    always_comb begin
        inst_o      = NOP;
        inst_addr_o = '0;
        if (fifo_vld) begin
            inst_o      = fi_q[f_rd_q];
            inst_addr_o = fa_q[f_rd_q];
        end else if (byp) begin
            inst_o      = imem_rdata_i;
            inst_addr_o = rsp_addr;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        o_cnt_d = o_cnt_q + CW'(grant) - CW'(rsp_vld);
        o_wr_d  = o_wr_q + PW'(grant);
        o_rd_d  = o_rd_q + PW'(rsp_vld);
        f_cnt_d = f_cnt_q + CW'(f_push) - CW'(f_pop);
        f_wr_d  = f_wr_q + PW'(f_push);
        f_rd_d  = f_rd_q + PW'(f_pop);
        d_cnt_d = d_cnt_q - CW'(rsp_vld && (d_cnt_q != '0));
        if (jump_flag_i) begin
            pc_d    = jump_addr_i;
            f_cnt_d = '0;
            f_wr_d  = '0;
            f_rd_d  = '0;
            // Everything still outstanding after this cycle belongs to the old stream.
            d_cnt_d = o_cnt_q - CW'(rsp_vld);
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            f_rd_q  <= '0;
            f_wr_q  <= '0;
            o_rd_q  <= '0;
            o_wr_q  <= '0;
            f_cnt_q <= '0;
            o_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            pc_q    <= pc_d;
            f_rd_q  <= f_rd_d;
            f_wr_q  <= f_wr_d;
            o_rd_q  <= o_rd_d;
            o_wr_q  <= o_wr_d;
            f_cnt_q <= f_cnt_d;
            o_cnt_q <= o_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            oa_q[o_wr_q] <= pc_q;
        end
        if (f_push) begin
            fa_q[f_wr_q] <= rsp_addr;
            fi_q[f_wr_q] <= imem_rdata_i;
        end
    end

`ifndef SYNTHESIS
    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> (o_cnt_q != '0));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a latency-configurable memory model and an in-order address scoreboard.
module tb_ifu_fetch;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        fetch_stall_o;

    ifu_fetch #(.RESET_ADDR(32'h0000_0100), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o),
        .fetch_stall_o(fetch_stall_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc, lat, stale_cnt, f_model;
    bit gnt_en;
    logic [31:0] exp_pc;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    bit          mq_stale[$];
    logic [31:0] exp_q[$];
    logic [31:0] cons_log[$];
    logic        s_req, s_vld, s_stall, s_rv_fresh, s_cons;
    logic [31:0] s_addr, s_inst, s_iaddr, s_cons_addr, held_addr;
    bit          found;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_0400) return 32'h0010_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, sample outputs, compare with model, advance model, cross the edge.
    task automatic tick();
        bit rv, rv_fresh, byp_now, exp_vld, exp_req, consume;
        rv = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        rv_fresh = rv ? !mq_stale[0] : 1'b0;
        imem_rvalid_i = rv;
        imem_rdata_i  = 32'h0;
        if (rv) imem_rdata_i = memfn(mq_addr[0]);
        imem_gnt_i = gnt_en;
        #1;
        s_req = imem_req_o; s_addr = imem_addr_o; s_vld = inst_valid_o;
        s_inst = inst_o; s_iaddr = inst_addr_o; s_stall = fetch_stall_o;
        s_rv_fresh = rv_fresh; s_cons = 1'b0; s_cons_addr = 32'h0;

        exp_req = !rst && !jump_flag_i && ((exp_q.size() + stale_cnt) < DEPTH);
        byp_now = BYP && !rst && rv_fresh && !jump_flag_i && (f_model == 0);
        exp_vld = !rst && !jump_flag_i && ((f_model > 0) || byp_now);
        if (!rst) begin
            chk("req", s_req, exp_req);
            if (exp_req) chk("fetch_addr", s_addr, exp_pc);
            chk("valid", s_vld, exp_vld);
            chk("stall", s_stall, !exp_vld);
            chk("inst_addr", s_iaddr, exp_vld ? exp_q[0] : 32'h0);
            chk("inst", s_inst, exp_vld ? memfn(exp_q[0]) : NOP);
        end

        consume = exp_vld && !hold_flag_i;
        if (jump_flag_i) begin
            exp_q.delete();
            f_model = 0;
            foreach (mq_stale[i]) mq_stale[i] = 1'b1;
            stale_cnt = mq_addr.size();
            exp_pc = jump_addr_i;
        end else begin
            if (consume) begin
                s_cons = 1'b1;
                s_cons_addr = exp_q.pop_front();
                cons_log.push_back(s_cons_addr);
                if (f_model > 0) f_model--;
            end
            if (rv_fresh && !(byp_now && !hold_flag_i)) f_model++;
            if (s_req && imem_gnt_i) begin
                mq_addr.push_back(s_addr);
                mq_due.push_back(cyc + lat);
                mq_stale.push_back(1'b0);
                exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (rv) begin
            if (mq_stale[0]) stale_cnt--;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            void'(mq_stale.pop_front());
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_addr);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (s_vld) found = 1'b1;
        end
        chk({tag, "_seen"}, {31'b0, found}, 32'd1);
        chk({tag, "_addr"}, s_iaddr, exp_addr);
    endtask

    task automatic drain();
        gnt_en = 1'b0;
        repeat (8) tick();
        gnt_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        cyc = -3; lat = 1; gnt_en = 1'b1; exp_pc = 32'h100; stale_cnt = 0; f_model = 0;
        @(negedge clk);

        // Reset behaviour
        repeat (3) begin
            tick();
            chk("rst_req", s_req, 32'd0);
            chk("rst_valid", s_vld, 32'd0);
            chk("rst_stall", s_stall, 32'd1);
            chk("rst_inst", s_inst, NOP);
            chk("rst_inst_addr", s_iaddr, 32'h0);
        end
        rst = 1'b0;

        // Reset release: first fetch at RESET_ADDR, head valid at cycle 2 (cycle 1 with bypass)
        tick();
        chk("rel_req0", s_req, 32'd1);
        chk("rel_addr0", s_addr, 32'h100);
        tick();
        chk("rel_c1_valid", s_vld, {31'b0, BYP});
        tick();
`ifndef IFU_BYPASS_EN
        chk("rel_c2_valid", s_vld, 32'd1);
        chk("rel_c2_addr", s_iaddr, 32'h100);
`endif
        repeat (5) tick();

        // Hold for 5 cycles: head frozen, fetch stops once capacity is reached
        held_addr = exp_q[0];
        hold_flag_i = 1'b1;
        repeat (5) begin
            tick();
            chk("hold_valid", s_vld, 32'd1);
            chk("hold_head", s_iaddr, held_addr);
        end
        chk("hold_req_dropped", s_req, 32'd0);
        hold_flag_i = 1'b0;
        tick();
        chk("release_first", s_cons ? s_cons_addr : 32'hFFFF_FFFF, held_addr);
        tick();
        chk("release_next", s_cons ? s_cons_addr : 32'hFFFF_FFFF, held_addr + 32'd4);
        repeat (4) tick();

        // Jump with two requests in flight (latency 3), no response in the jump cycle
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq_addr.size() == 2 && stale_cnt == 0 && f_model == 0 && mq_due[0] > cyc) found = 1'b1;
            else tick();
        end
        chk("inflight_setup", {31'b0, found}, 32'd1);
        jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        tick();
        jump_flag_i = 1'b0;
        chk("inflight_dcnt", 32'(dut.d_cnt_q), 32'd2);
        wait_valid("inflight_first", 32'h200);
        repeat (4) tick();

        // Jump in the same cycle as a live response: that word dropped, one left to discard
        lat = 2;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq_addr.size() == 2 && stale_cnt == 0 && mq_due[0] <= cyc) found = 1'b1;
            else tick();
        end
        chk("coincide_setup", {31'b0, found}, 32'd1);
        jump_flag_i = 1'b1; jump_addr_i = 32'h300;
        tick();
        jump_flag_i = 1'b0;
        chk("coincide_rv_fresh", {31'b0, s_rv_fresh}, 32'd1);
        chk("coincide_dcnt", 32'(dut.d_cnt_q), 32'd1);
        wait_valid("coincide_first", 32'h300);
        repeat (3) tick();

        // PC wrap from the top of the address space
        drain();
        lat = 1;
        jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
        tick();
        jump_flag_i = 1'b0;
        cons_log.delete();
        tick();
        chk("wrap_req0", s_req, 32'd1);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_req1", s_req, 32'd1);
        chk("wrap_addr1", s_addr, 32'h0000_0000);
        for (int i = 0; i < 20 && cons_log.size() < 2; i++) tick();
        chk("wrap_cons_cnt", 32'(cons_log.size()), 32'd2);
        if (cons_log.size() >= 2) begin
            chk("wrap_cons0", cons_log[0], 32'hFFFF_FFFC);
            chk("wrap_cons1", cons_log[1], 32'h0000_0000);
        end

        // Empty-FIFO response: same-cycle with bypass, next cycle without
        drain();
        jump_flag_i = 1'b1; jump_addr_i = 32'h400;
        tick();
        jump_flag_i = 1'b0;
        tick();
        tick();
        chk("byp_rv_cycle", {31'b0, s_rv_fresh}, 32'd1);
        chk("byp_valid", s_vld, {31'b0, BYP});
        chk("byp_inst", s_inst, BYP ? 32'h0010_0093 : NOP);
        tick();
        chk("byp_next_addr", s_iaddr, BYP ? 32'h404 : 32'h400);
        repeat (3) tick();

        // Same with hold: the word stays at the head for the following cycle
        drain();
        jump_flag_i = 1'b1; jump_addr_i = 32'h400;
        tick();
        jump_flag_i = 1'b0;
        hold_flag_i = 1'b1;
        tick();
        tick();
        chk("bhold_valid", s_vld, {31'b0, BYP});
        chk("bhold_inst", s_inst, BYP ? 32'h0010_0093 : NOP);
        tick();
        chk("bhold_next_valid", s_vld, 32'd1);
        chk("bhold_next_inst", s_inst, 32'h0010_0093);
        chk("bhold_next_addr", s_iaddr, 32'h400);
        hold_flag_i = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
